// File: rtl/bus_arbiter_65xx.sv
// bus_arbiter_65xx: shares the single BRAM port between the 65xx CPU and one DMA master (optional burst cap: DMA_BURST_LIMIT_EN).
// Latency: ownership changes one clock after the deciding edge; RAM read data returns one clock after the address.
// Backpressure: CPU stalled with cpu_rdy=0, DMA access accepted on dma_gnt&dma_req; grant only taken on CPU read cycles.
`timescale 1ns/1ps
module bus_arbiter_65xx #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic              cpu_rdy,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_we,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {S_CPU, S_DMA} state_t;

    state_t            state;
    logic              prev_cpu;
    logic [DATA_W-1:0] hold;
    logic              dma_acc;
    logic              go_dma;
    logic              go_cpu;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..255");
    end

    assign dma_acc = (state == S_DMA) & dma_req;

`ifdef DMA_BURST_LIMIT_EN
    logic [7:0] burst_cnt;
    logic       owe;
    logic       burst_last;

    // The MAX_BURST-th accepted access of a grant forces the bus back to the CPU.
    assign burst_last = dma_acc & (burst_cnt == 8'(MAX_BURST - 1));
    assign go_dma     = (state == S_CPU) & dma_req & ~cpu_we & ~owe;
    assign go_cpu     = (state == S_DMA) & (~dma_req | burst_last);

    // Burst counter and the owe flag that guarantees the CPU two cycles after a forced release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= 8'd0;
            owe       <= 1'b0;
        end else begin
            if (go_dma)
                burst_cnt <= 8'd0;
            else if (dma_acc && burst_cnt != 8'hFF)
                burst_cnt <= burst_cnt + 8'd1;
            if (burst_last)
                owe <= 1'b1;
            else if (state == S_CPU)
                owe <= 1'b0;
        end
    end
`else
    assign go_dma = (state == S_CPU) & dma_req & ~cpu_we;
    assign go_cpu = (state == S_DMA) & ~dma_req;
`endif

    // Ownership FSM; cpu_rdy/dma_gnt are flops so dma_req and cpu_we never reach them combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_CPU;
            cpu_rdy <= 1'b1;
            dma_gnt <= 1'b0;
        end else if (go_dma) begin
            state   <= S_DMA;
            cpu_rdy <= 1'b0;
            dma_gnt <= 1'b1;
        end else if (go_cpu) begin
            state   <= S_CPU;
            cpu_rdy <= 1'b1;
            dma_gnt <= 1'b0;
        end
    end

    // RAM port mux; an idle DMA cycle (dma_req=0) never writes.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        if (state == S_DMA) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we & dma_req;
        end
    end

    // Read-return tracking: DMA read valid one cycle after acceptance, and the CPU read that was
    // in flight when the DMA took over is parked in hold until the CPU owns the port again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_rvalid <= 1'b0;
            prev_cpu   <= 1'b1;
            hold       <= '0;
        end else begin
            dma_rvalid <= dma_acc & ~dma_we;
            prev_cpu   <= (state == S_CPU);
            if (prev_cpu && state == S_DMA)
                hold <= mem_rdata;
        end
    end

    assign cpu_rdata = prev_cpu ? mem_rdata : hold;
    assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_bus_arbiter_65xx.sv
// tb_bus_arbiter_65xx: randomized CPU/DMA traffic against bus_arbiter_65xx with a BRAM model and a reference memory.
// Latency: expects read data one cycle after acceptance, ownership changes one cycle after the deciding edge.
// Backpressure: CPU and DMA drivers hold their access until the arbiter accepts it.
`timescale 1ns/1ps
module tb_bus_arbiter_65xx;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MAXB = 8;
`ifdef DMA_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_we, cpu_rdy, dma_req, dma_we, dma_gnt, dma_rvalid, mem_we;

    bus_arbiter_65xx #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM with one cycle read latency.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct { bit req; bit we; logic [15:0] addr; logic [7:0] data; } acc_t;
    typedef struct { logic [7:0] data; int due; } exp_t;

    logic [7:0] ref_mem [0:65535];
    acc_t cpu_q[$], dma_q[$];
    acc_t cpu_cur, dma_cur;
    exp_t cpu_exp[$], dma_exp[$];
    int   checks = 0, passes = 0, cyc = 0, max_run = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic acc_t next_cpu();
        if (cpu_q.size() != 0) return cpu_q.pop_front();
        return acc_t'{1'b1, 1'b0, 16'h0010, 8'h00};
    endfunction

    function automatic acc_t next_dma();
        if (dma_q.size() != 0) return dma_q.pop_front();
        return acc_t'{1'b0, 1'b0, 16'h0000, 8'h00};
    endfunction

    task automatic apply();
        cpu_we  = cpu_cur.we;  cpu_addr = cpu_cur.addr; cpu_wdata = cpu_cur.data;
        dma_req = dma_cur.req; dma_we   = dma_cur.we;   dma_addr  = dma_cur.addr; dma_wdata = dma_cur.data;
    endtask

    // Drivers: each master holds its access until the arbiter accepts it.
    initial begin : drv
        bit a_cpu, a_dma;
        forever begin
            @(negedge clk);
            a_cpu = cpu_rdy;
            a_dma = dma_gnt & dma_req;
            @(posedge clk);
            #1;
            if (reset_n && a_cpu) cpu_cur = next_cpu();
            if (reset_n && (!dma_cur.req || a_dma)) dma_cur = next_dma();
            apply();
        end
    end

    // Reference model: accepted accesses hit one flat memory in order; reads push the expected byte.
    acc_t p_cpu, p_dma;
    bit   p_cpu_v, p_dma_v;
    always @(negedge clk) begin
        p_cpu_v = cpu_rdy;
        p_cpu   = acc_t'{1'b1, cpu_we, cpu_addr, cpu_wdata};
        p_dma_v = dma_gnt & dma_req;
        p_dma   = acc_t'{1'b1, dma_we, dma_addr, dma_wdata};
    end

    function automatic void commit(input acc_t a, input bit is_dma);
        exp_t e;
        if (a.we) ref_mem[a.addr] = a.data;
        else begin
            e.data = ref_mem[a.addr];
            e.due  = cyc;
            if (is_dma) dma_exp.push_back(e);
            else        cpu_exp.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset_n) begin
            if (p_cpu_v) commit(p_cpu, 1'b0);
            if (p_dma_v) commit(p_dma, 1'b1);
        end
    end

    // CPU read monitor: fresh data one cycle after acceptance, held steady while stalled.
    logic [7:0] cur;
    bit         cur_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            cur_v = 1'b0;
            cpu_exp.delete();
        end else if (cpu_exp.size() != 0 && cpu_exp[0].due == cyc) begin
            e = cpu_exp.pop_front();
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
            cur   = e.data;
            cur_v = 1'b1;
        end else if (!cpu_rdy && cur_v) begin
            chk("cpu_rdata_stall_hold", 32'(cpu_rdata), 32'(cur));
        end
    end

    // DMA read monitor: dma_rvalid exactly on the cycle after each accepted read.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) dma_exp.delete();
        else if (dma_rvalid) begin
            if (dma_exp.size() == 0 || dma_exp[0].due != cyc) chk("dma_rvalid_spurious", 32'(dma_rvalid), 32'd0);
            else begin
                e = dma_exp.pop_front();
                chk("dma_rdata", 32'(dma_rdata), 32'(e.data));
            end
        end else if (dma_exp.size() != 0 && dma_exp[0].due <= cyc) begin
            e = dma_exp.pop_front();
            chk("dma_rvalid_missing", 32'(dma_rvalid), 32'd1);
        end
    end

    // Ownership rules: one owner, port follows the owner, grant/release timing, optional burst cap.
    bit pv = 1'b0, p_gnt, p_req, p_cwe, forced = 1'b0;
    int run = 0, ccnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            pv = 1'b0; run = 0; ccnt = 0; forced = 1'b0;
        end else begin
            chk("owner_onehot", 32'(cpu_rdy), 32'(!dma_gnt));
            chk("mem_addr", 32'(mem_addr), 32'(dma_gnt ? dma_addr : cpu_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(dma_gnt ? dma_wdata : cpu_wdata));
            chk("mem_we", 32'(mem_we), 32'(dma_gnt ? (dma_we & dma_req) : cpu_we));
            if (pv)
                chk("dma_gnt_timing", 32'(dma_gnt),
                    32'(p_gnt ? (p_req && !forced) : (p_req && !p_cwe && !(forced && ccnt == 1))));
            if (dma_gnt) begin
                if (!pv || !p_gnt) run = 0;
                ccnt = 0;
                if (dma_req) run++;
                if (run > max_run) max_run = run;
                forced = LIMIT && (run >= MAXB);
            end else begin
                ccnt++;
            end
            pv = 1'b1; p_gnt = dma_gnt; p_req = dma_req; p_cwe = cpu_we;
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((cpu_q.size() != 0 || dma_q.size() != 0 || dma_cur.req) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(n < 5000), 32'd1);
        repeat (4) @(posedge clk);
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int extra [14] = '{16'h0200, 16'h0201, 16'h0300, 16'h1000, 16'h1001, 16'h1002, 16'h1003,
                           16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005, 16'h0010};
        int n;
        logic [7:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            ram[i] <= v;
            ref_mem[i] = v;
        end
        ram[16'h0200] <= 8'h5A; ref_mem[16'h0200] = 8'h5A;
        ram[16'h0201] <= 8'hA5; ref_mem[16'h0201] = 8'hA5;
        cpu_cur = next_cpu();
        dma_cur = next_dma();
        apply();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("reset_dma_rvalid", 32'(dma_rvalid), 32'd0);
        #2 reset_n = 1'b1;

        // CPU write blocks grant, CPU read hands off, DMA burst of 4 writes + 2 reads, CPU re-reads
        cpu_q.push_back(acc_t'{1'b1, 1'b1, 16'h0300, 8'h77});
        cpu_q.push_back(acc_t'{1'b1, 1'b0, 16'h0200, 8'h00});
        cpu_q.push_back(acc_t'{1'b1, 1'b0, 16'h0201, 8'h00});
        cpu_q.push_back(acc_t'{1'b1, 1'b0, 16'h0300, 8'h00});
        cpu_q.push_back(acc_t'{1'b1, 1'b0, 16'h1000, 8'h00});
        dma_q.push_back(acc_t'{1'b1, 1'b1, 16'h1000, 8'h11});
        dma_q.push_back(acc_t'{1'b1, 1'b1, 16'h1001, 8'h22});
        dma_q.push_back(acc_t'{1'b1, 1'b1, 16'h1002, 8'h33});
        dma_q.push_back(acc_t'{1'b1, 1'b1, 16'h1003, 8'h44});
        dma_q.push_back(acc_t'{1'b1, 1'b0, 16'h1000, 8'h00});
        dma_q.push_back(acc_t'{1'b1, 1'b0, 16'h1001, 8'h00});
        drain("directed_drain");

        // Reset asserted in the middle of a DMA write burst
        for (int i = 0; i < 6; i++) dma_q.push_back(acc_t'{1'b1, 1'b1, 16'(16'h2000 + i), 8'($urandom)});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dma_gnt && dma_we && dma_req) && n < 200);
        chk("reset_mid_dma_reached", 32'(dma_gnt & dma_we & dma_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_mid_dma_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mid_dma_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset_mid_dma_gnt", 32'(dma_gnt), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        drain("reset_drain");

        // Long held request: 20 back-to-back DMA accesses
        max_run = 0;
        for (int i = 0; i < 20; i++)
            dma_q.push_back(acc_t'{1'b1, bit'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 8'($urandom)});
        drain("burst_drain");
        chk("longest_dma_burst", 32'(max_run), LIMIT ? 32'(MAXB) : 32'd20);

        // Randomized mixed traffic on a small address window
        for (int i = 0; i < 400; i++) begin
            cpu_q.push_back(acc_t'{1'b1, ($urandom_range(0, 9) < 3), 16'($urandom_range(0, 63)), 8'($urandom)});
            dma_q.push_back(acc_t'{($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)),
                                   16'($urandom_range(0, 63)), 8'($urandom)});
        end
        drain("random_drain");

        // Final RAM contents against the reference memory
        for (int a = 0; a < 64; a++) chk("ram_contents", 32'(ram[a]), 32'(ref_mem[a]));
        for (int i = 0; i < 14; i++) chk("ram_contents", 32'(ram[extra[i]]), 32'(ref_mem[extra[i]]));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
